// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with memory-wait FSM and perf counters
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {RUN, MWAIT} state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

  logic              wait_hz;
  logic              lu_hz;
  logic              branch_fire;

  assign wait_hz = mem_req & ~mem_ready;
  assign lu_hz   = ex_mem_read & (ex_rd != 5'd0) &
                   ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Prioritised hazard actions; everything is held low while reset is asserted.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    branch_fire  = 1'b0;
    if (!rst) begin
      if (wait_hz) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_br_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        branch_fire  = 1'b1;
      end else if (lu_hz) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Memory-wait FSM next state, saturating wait counter and sticky timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        if (wait_hz) begin
          state_d    = MWAIT;
          wait_cnt_d = TO_W'(1);
        end
      end
      MWAIT: begin
        if (mem_ready || !mem_req) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != TO_W'(TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (state_d == MWAIT && wait_cnt_d == TO_W'(TIMEOUT)) begin
      timeout_d = 1'b1;
    end
  end

  // FSM state, wait counter and timeout flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (branch_fire && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector and sequence bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int TO_W  = 3;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_WAIT = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, mem_req, mem_ready, cnt_clr;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_flush(mem_wb_flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic drive_lu();
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_mem_read = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vt[2]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[3]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vt[4]  = '{5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[5]  = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR};
    vt[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
    vt[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_WAIT};
    vt[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vt[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR};

    // Reset: controls forced low even with active hazard inputs.
    rst = 1'b1;
    idle();
    mem_req = 1'b1; ex_br_taken = 1'b1; drive_lu();
    #7;
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    check("rst_stall_cnt", 32'(stall_cycles), 0);
    check("rst_flush_cnt", 32'(flush_events), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    idle();
    tick();
    rst = 1'b0;

    // Table-driven single-cycle control vectors.
    for (int i = 0; i < 11; i++) begin
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2;
      id_use_rs1 = vt[i].u1; id_use_rs2 = vt[i].u2;
      ex_rd = vt[i].rd; ex_mem_read = vt[i].ld; ex_br_taken = vt[i].br;
      mem_req = vt[i].req; mem_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vt[i].exp));
      tick();
    end
    idle();
    pulse_reset();

    // Load-use: exactly one bubble, then load moves to MEM.
    drive_lu();
    #1;
    check("lu_cycle1", 32'(ctl), 32'(C_LU));
    tick();
    idle();
    #1;
    check("lu_cycle2", 32'(ctl), 32'(C_NONE));
    check("lu_stall_cnt", 32'(stall_cycles), 1);
    tick();

    // Branch together with load-use match: branch wins.
    drive_lu(); ex_br_taken = 1'b1;
    #1;
    check("br_lu_ctl", 32'(ctl), 32'(C_BR));
    tick();
    idle();
    check("br_flush_cnt", 32'(flush_events), 1);
    check("br_stall_cnt", 32'(stall_cycles), 1);
    pulse_reset();

    // Three-cycle memory wait with a branch held across it.
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0; ex_br_taken = 1'b1;
      #1;
      check($sformatf("wait%0d_ctl", i), 32'(ctl), 32'(C_WAIT));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("wait_done_ctl", 32'(ctl), 32'(C_BR));
    tick();
    idle();
    check("wait_stall_cnt", 32'(stall_cycles), 3);
    check("wait_flush_cnt", 32'(flush_events), 1);
    check("wait_no_timeout", 32'(mem_timeout), 0);
    // A fresh 3-cycle wait must not time out if the wait counter restarted.
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
    end
    check("rewait_no_timeout", 32'(mem_timeout), 0);
    idle();
    tick();
    pulse_reset();

    // Timeout: six wait cycles, flag rises as wait_cnt reaches TIMEOUT.
    for (int i = 1; i <= 6; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
      check($sformatf("to_edge%0d", i), 32'(mem_timeout), (i >= TO) ? 1 : 0);
    end
    check("to_stall_cnt", 32'(stall_cycles), 6);
    mem_ready = 1'b1;
    #1;
    check("to_ready_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    check("to_sticky1", 32'(mem_timeout), 1);
    idle();
    tick();
    check("to_sticky2", 32'(mem_timeout), 1);
    rst = 1'b1;
    #1;
    check("to_rst_clear", 32'(mem_timeout), 0);
    rst = 1'b0;
    tick();

    // Counter saturation and clear-over-increment.
    for (int i = 0; i < 20; i++) begin
      drive_lu();
      tick();
    end
    check("sat_stall_cnt", 32'(stall_cycles), 15);
    cnt_clr = 1'b1;
    #1;
    check("clr_lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    check("clr_stall_cnt", 32'(stall_cycles), 0);
    idle();
    tick();

    // Asynchronous reset during the second wait cycle.
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    check("mid_stall_cnt", 32'(stall_cycles), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctl", 32'(ctl), 32'(C_NONE));
    check("mid_rst_cnt", 32'(stall_cycles), 0);
    check("mid_rst_to", 32'(mem_timeout), 0);
    tick();
    rst = 1'b0;
    idle();
    tick();
    check("post_rst_cnt", 32'(stall_cycles), 0);
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_ready = 1'b0;
      tick();
    end
    check("post_rst_no_to", 32'(mem_timeout), 0);
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
